// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles, branch/jump flushes, data-memory waits.
// Optional build macro PIPE_PERF_CNT_EN adds stall_cycles, flush_count and load_use_count counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 200,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_ex,
  input  logic [4:0]  rt_ex,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic        branch_taken_ex,
  input  logic        jump_id,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic        mem_wb_hold,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] load_use_count,
`endif
  output logic        mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  // Winning hazard for the current cycle, highest priority first.
  typedef enum logic [2:0] {
    PRI_RESET, PRI_STALL, PRI_FLUSH, PRI_LOAD_USE, PRI_JUMP, PRI_NONE
  } pri_e;

  state_e              state_q;
  logic                pending_flush_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                mem_timeout_q;

  logic mem_stall;
  logic load_use;
  logic flush_now;
  pri_e pri;

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = mem_read_ex && (rt_ex != 5'd0) &&
                     ((use_rs_id && (rs_id == rt_ex)) || (use_rt_id && (rt_id == rt_ex)));
  assign flush_now = branch_taken_ex || pending_flush_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pri = PRI_NONE;
    if (reset)          pri = PRI_RESET;
    else if (mem_stall) pri = PRI_STALL;
    else if (flush_now) pri = PRI_FLUSH;
    else if (load_use)  pri = PRI_LOAD_USE;
    else if (jump_id)   pri = PRI_JUMP;
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    id_ex_hold  = 1'b0;
    ex_mem_hold = 1'b0;
    mem_wb_hold = 1'b0;
    unique case (pri)
      PRI_RESET: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
        mem_wb_hold = 1'b1;
      end
      PRI_STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
        mem_wb_hold = 1'b1;
      end
      // Kill wrong-path IF and ID instructions; IF/ID write is irrelevant under flush.
      PRI_FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      PRI_LOAD_USE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      PRI_JUMP: if_id_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q         <= RUN;
      pending_flush_q <= 1'b0;
      wait_cnt_q      <= '0;
      mem_timeout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q         <= MEM_WAIT;
            wait_cnt_q      <= WAIT_W'(1);
            pending_flush_q <= branch_taken_ex;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt_q != '1)                wait_cnt_q      <= wait_cnt_q + 1'b1;
            if (wait_cnt_q == WAIT_W'(MAX_WAIT)) mem_timeout_q   <= 1'b1;
            if (branch_taken_ex)                 pending_flush_q <= 1'b1;
          end else begin
            // The replayed flush was applied combinationally in this exit cycle.
            state_q         <= RUN;
            pending_flush_q <= 1'b0;
            wait_cnt_q      <= '0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;
  logic [31:0] load_use_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q   <= '0;
      flush_count_q    <= '0;
      load_use_count_q <= '0;
    end else begin
      if (!pc_write)             stall_cycles_q   <= stall_cycles_q + 32'd1;
      if (pri == PRI_FLUSH)      flush_count_q    <= flush_count_q + 32'd1;
      if (pri == PRI_LOAD_USE)   load_use_count_q <= load_use_count_q + 32'd1;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign flush_count    = flush_count_q;
  assign load_use_count = load_use_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (instantiated with MAX_WAIT=5 to reach the timeout quickly).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_read_ex;
  logic [4:0] rt_ex, rs_id, rt_id;
  logic       use_rs_id, use_rt_id;
  logic       branch_taken_ex, jump_id;
  logic       dmem_req, dmem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic       id_ex_hold, ex_mem_hold, mem_wb_hold, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, load_use_count;
`endif

  int errors = 0;
  int checks = 0;

  // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold, mem_wb_hold
  localparam logic [6:0] P_RESET = 7'b0011111;
  localparam logic [6:0] P_STALL = 7'b0000111;
  localparam logic [6:0] P_FLUSH = 7'b1111000;
  localparam logic [6:0] P_LU    = 7'b0001000;
  localparam logic [6:0] P_JUMP  = 7'b1110000;
  localparam logic [6:0] P_NORM  = 7'b1100000;

  pipeline_hazard_ctrl #(.MAX_WAIT(5), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset),
    .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .branch_taken_ex(branch_taken_ex), .jump_id(jump_id),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .mem_wb_hold(mem_wb_hold),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count), .load_use_count(load_use_count),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold, mem_wb_hold};
  endfunction

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_ex = 0; rt_ex = 0; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
    branch_taken_ex = 0; jump_id = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    for (int i = 0; i < 3; i++) begin
      #3; checks++;
      if ((outs() & 7'b1011111) !== P_RESET) begin
        errors++; $display("FAIL reset_pattern cyc=%0d got=%b exp=%b (if_id_write masked)", i, outs(), P_RESET);
      end
      tick();
    end
    reset = 1'b0;
    #3; checks++;
    if (outs() !== P_NORM || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_release got=%b timeout=%b exp=%b timeout=0", outs(), mem_timeout, P_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    // rs match, then load advanced to MEM: exactly one bubble
    mem_read_ex = 1; rt_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1;
    #3; checks++;
    if (outs() !== P_LU) begin errors++; $display("FAIL load_use_rs got=%b exp=%b", outs(), P_LU); end
    tick();
    mem_read_ex = 0;
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL load_use_after got=%b exp=%b", outs(), P_NORM); end
    tick();
    // rt match
    mem_read_ex = 1; rt_ex = 5'd3; rs_id = 5'd1; use_rs_id = 1; rt_id = 5'd3; use_rt_id = 1;
    #3; checks++;
    if (outs() !== P_LU) begin errors++; $display("FAIL load_use_rt got=%b exp=%b", outs(), P_LU); end
    tick();
    // rt matches but not used
    use_rt_id = 0;
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL load_use_unused got=%b exp=%b", outs(), P_NORM); end
    tick();
    // $zero destination never stalls
    rt_ex = 5'd0; rs_id = 5'd0; use_rs_id = 1;
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL load_use_r0 got=%b exp=%b", outs(), P_NORM); end
    tick();
    idle_inputs();
  endtask

  task automatic test_jump();
    jump_id = 1;
    #3; checks++;
    if (outs() !== P_JUMP) begin errors++; $display("FAIL jump got=%b exp=%b", outs(), P_JUMP); end
    tick();
    // load-use outranks a jump in ID
    mem_read_ex = 1; rt_ex = 5'd9; rs_id = 5'd9; use_rs_id = 1;
    #3; checks++;
    if (outs() !== P_LU) begin errors++; $display("FAIL jump_vs_load_use got=%b exp=%b", outs(), P_LU); end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      #3; checks++;
      if (outs() !== P_STALL) begin errors++; $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, outs(), P_STALL); end
      tick();
    end
    checks++;
    if (dut.wait_cnt_q !== 8'd4) begin errors++; $display("FAIL wait_cnt_mid got=%0d exp=4", dut.wait_cnt_q); end
    dmem_ready = 1;
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL mem_release got=%b exp=%b", outs(), P_NORM); end
    tick();
    checks++;
    if (dut.wait_cnt_q !== 8'd0) begin errors++; $display("FAIL wait_cnt_clear got=%0d exp=0", dut.wait_cnt_q); end
    // ready in the request cycle costs nothing
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL zero_wait got=%b exp=%b", outs(), P_NORM); end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_in_wait();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      branch_taken_ex = (i == 2);
      #3; checks++;
      if (outs() !== P_STALL) begin errors++; $display("FAIL branch_wait cyc=%0d got=%b exp=%b", i, outs(), P_STALL); end
      tick();
    end
    branch_taken_ex = 0; dmem_ready = 1;
    #3; checks++;
    if (outs() !== P_FLUSH) begin errors++; $display("FAIL branch_replay got=%b exp=%b", outs(), P_FLUSH); end
    tick();
    dmem_req = 0; dmem_ready = 0;
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL branch_replay_once got=%b exp=%b", outs(), P_NORM); end
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    branch_taken_ex = 1; mem_read_ex = 1; rt_ex = 5'd12; rs_id = 5'd12; use_rs_id = 1;
    #3; checks++;
    if (outs() !== P_FLUSH) begin errors++; $display("FAIL branch_load_use got=%b exp=%b", outs(), P_FLUSH); end
    tick();
    idle_inputs();
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL branch_load_use_after got=%b exp=%b", outs(), P_NORM); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    dmem_req = 1; dmem_ready = 0; branch_taken_ex = 1;
    tick();
    branch_taken_ex = 0;
    tick();
    reset = 1;
    #3; checks++;
    if ((outs() & 7'b1011111) !== P_RESET) begin errors++; $display("FAIL reset_in_wait got=%b exp=%b", outs(), P_RESET); end
    tick();
    reset = 0; dmem_req = 0;
    #3; checks++;
    if (outs() !== P_NORM) begin errors++; $display("FAIL reset_drops_pending got=%b exp=%b", outs(), P_NORM); end
    tick();
  endtask

  task automatic test_timeout();
    reset = 1; idle_inputs();
    tick();
    reset = 0; dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      #3; checks++;
      if (outs() !== P_STALL) begin errors++; $display("FAIL timeout_stall cyc=%0d got=%b exp=%b", i, outs(), P_STALL); end
      if (i <= 5) begin
        checks++;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early cyc=%0d got=%b exp=0", i, mem_timeout); end
      end
      if (i >= 7) begin
        checks++;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set cyc=%0d got=%b exp=1", i, mem_timeout); end
      end
      tick();
    end
    dmem_ready = 1;
    #3; checks++;
    if (outs() !== P_NORM || mem_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_release got=%b timeout=%b exp=%b timeout=1", outs(), mem_timeout, P_NORM);
    end
    tick();
    idle_inputs();
    tick();
    #3; checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout); end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd10) begin errors++; $display("FAIL perf_stall_cycles got=%0d exp=10", stall_cycles); end
`endif
    tick();
    reset = 1;
    tick();
    reset = 0;
    #3; checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_reset got=%b exp=0", mem_timeout); end
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_jump();
    test_mem_wait();
    test_branch_in_wait();
    test_branch_vs_load_use();
    test_reset_in_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It watches the ID and EX stages and the data-memory handshake, and drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch and jump flushes, and multi-cycle data-memory waits. A branch that resolves during a memory wait is held as a pending flush and replayed when the wait ends.

## Interface
- MAX_WAIT, 200: maximum cycles tolerated in MEM_WAIT before the timeout flag is set (1..2^WAIT_W-1).
- WAIT_W, 8: width of the wait counter.

- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- mem_read_ex  input  1  EX-stage instruction is a load.
- rt_ex  input  5  load destination register in EX.
- rs_id, rt_id  input  5 each  source registers of the ID instruction.
- use_rs_id, use_rt_id  input  1 each  ID instruction actually reads rs or rt.
- branch_taken_ex  input  1  branch in EX resolved as taken.
- jump_id  input  1  ID instruction is j/jal/jr.
- dmem_req  input  1  MEM stage is issuing a load or store this cycle.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID clear to NOP.
- id_ex_flush  output  1  ID/EX bubble insert.
- id_ex_hold, ex_mem_hold, mem_wb_hold  output  1 each  freeze the named register.
- mem_timeout  output  1  sticky error flag: MAX_WAIT exceeded.

## Operation
- FSM states: RUN, MEM_WAIT.
- Registered state: state, pending_flush, wait_cnt[WAIT_W-1:0], mem_timeout.
- Signal definitions:
  - mem_stall = dmem_req && !dmem_ready.
  - load_use = mem_read_ex && rt_ex != 0 && ((use_rs_id && rs_id == rt_ex) || (use_rt_id && rt_id == rt_ex)).
  - flush_now = branch_taken_ex || pending_flush.
- Output priority, highest first, evaluated every cycle in either state:
  - reset: pc_write=0, if_id_write=0, all holds=1, if_id_flush=1, id_ex_flush=1.
  - mem_stall: pc_write=0, if_id_write=0, all holds=1, no flushes.
  - flush_now: pc_write=1, if_id_flush=1, id_ex_flush=1, holds=0. This kills the wrong-path IF and ID instructions.
  - load_use: pc_write=0, if_id_write=0, id_ex_flush=1. This gives a 1-cycle bubble.
  - jump_id: pc_write=1, if_id_flush=1.
  - otherwise: pc_write=1, if_id_write=1, all holds=0, no flushes.
- Flush/write overlap: whenever if_id_flush=1, if_id_write is don't-care; drive it as 1.
- RUN -> MEM_WAIT when mem_stall. On that transition:
  - wait_cnt <= 1.
  - pending_flush <= branch_taken_ex.
- MEM_WAIT, while mem_stall: stay.
  - wait_cnt increments and saturates at 2^WAIT_W-1.
  - If wait_cnt == MAX_WAIT, set mem_timeout.
  - If branch_taken_ex is seen, OR it into pending_flush.
- MEM_WAIT -> RUN when !mem_stall (dmem_ready=1 or dmem_req dropped). Effects:
  - In the exit cycle, outputs follow the priority list above, so a pending flush is applied in that cycle.
  - pending_flush clears on the following edge.
  - wait_cnt clears.
- In RUN, pending_flush is 0.
- mem_timeout clears only on reset.

## Timing
- All hazard outputs are combinational from the current inputs plus registered state, and are valid in the same cycle.
- State updates on posedge clk.
- Reset asserted for N cycles:
  - state=RUN, pending_flush=0, wait_cnt=0, mem_timeout=0.
  - Outputs hold the reset pattern for those N cycles.
  - Normal outputs resume in the first cycle after deassertion.
- Reset asserted mid-MEM_WAIT: abandons the wait and the pending flush on the next edge.
- Load-use costs 1 cycle. In the next cycle the load is in MEM, so load_use is 0 unless a mem_stall freezes the pipeline.
- Memory access with dmem_ready=1 in the request cycle costs 0 stall cycles.
- branch_taken_ex with mem_stall in the same cycle: no flush that cycle; the flush is applied in the cycle the wait ends.
- branch_taken_ex with load_use in the same cycle: the flush wins and no stall is taken.

## Configuration
- PIPE_PERF_CNT_EN, when defined, adds three outputs. Each is 32 bits wide, wraps modulo 2^32, and resets to 0.
  - stall_cycles: counts cycles with pc_write=0 outside reset.
  - flush_count: counts cycles with id_ex_flush=1 caused by flush_now.
  - load_use_count: counts cycles where load_use is the winning priority.
- When undefined, these ports and their logic are absent, and there is no other behavioural change.

## Test plan
- Reset held 3 cycles -> pc_write=0, if_id_flush=1, id_ex_flush=1 throughout. First cycle after release: pc_write=1, mem_timeout=0.
- mem_read_ex=1, rt_ex=8, rs_id=8, use_rs_id=1 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. Same stimulus with rt_ex=0 -> no stall.
- dmem_req=1, dmem_ready=0 for 4 cycles, then 1 -> holds=1 and pc_write=0 for 4 cycles, release in cycle 5, wait_cnt back to 0.
- branch_taken_ex=1 pulsed in the 2nd cycle of a 4-cycle memory wait -> no flush during the wait. if_id_flush=1 and id_ex_flush=1 in the exit cycle only.
- Same cycle: branch_taken_ex=1 and load_use condition -> flush pattern, pc_write=1, no bubble cycle after.
- MAX_WAIT=5 with dmem_ready held 0 for 10 cycles -> mem_timeout rises after the 5th wait cycle and stays 1 after dmem_ready returns, until reset. With PIPE_PERF_CNT_EN defined, stall_cycles=10.
